// File: rtl/gmii_rx_framer.sv
// rtl/gmii_rx_framer.sv - GMII receive framer: preamble/SFD strip, FCS and length check, SFD timestamp
// One byte of hold delay lets the last byte carry out_eof, since end of frame is only known when dv falls.
module gmii_rx_framer #(
  parameter int MIN_PREAMBLE  = 2,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic        gmii_rx_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [63:0] global_counter,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic [10:0] out_len,
  output logic        out_crc_ok,
  output logic        out_err,
  output logic [63:0] out_tstamp,
  output logic [31:0] frame_cnt,
  output logic [31:0] err_cnt
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  pre_cnt;
  logic [31:0] crc;
  logic [10:0] len;
  logic        er_seen;
  logic        hold_valid;
  logic        hold_first;
  logic [7:0]  hold_data;

  logic sfd_ok, sfd_hit, take_byte, end_frame, emit, eof_now, crc_ok, frame_bad;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  always_ff @(posedge gmii_rx_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (gmii_rx_dv) state_nxt = (gmii_rxd == 8'h55) ? PRE : DROP;
      PRE: begin
        if (!gmii_rx_dv)             state_nxt = IDLE;
        else if (gmii_rxd == 8'h55)  state_nxt = PRE;
        else if (sfd_ok)             state_nxt = DATA;
        else                         state_nxt = DROP;
      end
      DATA: if (!gmii_rx_dv) state_nxt = IDLE;
      DROP: if (!gmii_rx_dv) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sfd_ok    = (gmii_rxd == 8'hD5) && (int'(pre_cnt) >= MIN_PREAMBLE);
    sfd_hit   = (state == PRE) && gmii_rx_dv && sfd_ok;
    take_byte = (state == DATA) && gmii_rx_dv;
    end_frame = (state == DATA) && !gmii_rx_dv;
    emit      = (take_byte || end_frame) && hold_valid;
    eof_now   = end_frame && hold_valid;
    crc_ok    = (crc == CRC_RESIDUE);
    frame_bad = !crc_ok || (int'(len) < MIN_FRAME_LEN) || (int'(len) > MAX_FRAME_LEN) || er_seen;
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (!sys_rst_n) begin
      pre_cnt    <= 4'd0;
      crc        <= 32'hFFFF_FFFF;
      len        <= 11'd0;
      er_seen    <= 1'b0;
      hold_valid <= 1'b0;
      hold_first <= 1'b0;
      hold_data  <= 8'd0;
      out_valid  <= 1'b0;
      out_data   <= 8'd0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_len    <= 11'd0;
      out_crc_ok <= 1'b0;
      out_err    <= 1'b0;
      out_tstamp <= 64'd0;
      frame_cnt  <= 32'd0;
      err_cnt    <= 32'd0;
    end else begin
      if (state == IDLE)
        pre_cnt <= 4'd1;
      else if (state == PRE && gmii_rxd == 8'h55 && pre_cnt != 4'hF)
        pre_cnt <= pre_cnt + 4'd1;

      if (sfd_hit) begin
        crc        <= 32'hFFFF_FFFF;
        len        <= 11'd0;
        er_seen    <= 1'b0;
        hold_valid <= 1'b0;
        out_tstamp <= global_counter;
      end else if (take_byte) begin
        crc        <= crc32_byte(crc, gmii_rxd);
        if (len != 11'h7FF) len <= len + 11'd1;
        er_seen    <= er_seen | gmii_rx_er;
        hold_data  <= gmii_rxd;
        hold_first <= !hold_valid;
        hold_valid <= 1'b1;
      end else if (end_frame) begin
        hold_valid <= 1'b0;
      end

      // Status fields are forced to zero except on the eof beat.
      out_valid  <= emit;
      out_data   <= emit ? hold_data : 8'd0;
      out_sof    <= emit && hold_first;
      out_eof    <= eof_now;
      out_len    <= eof_now ? len : 11'd0;
      out_crc_ok <= eof_now && crc_ok;
      out_err    <= eof_now && frame_bad;
      frame_cnt  <= frame_cnt + 32'(eof_now);
      err_cnt    <= err_cnt + 32'(eof_now && frame_bad);
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// tb/tb_gmii_rx_framer.sv - self-checking bench for gmii_rx_framer
`timescale 1ns/1ps
module tb_gmii_rx_framer;

  logic        gmii_rx_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [63:0] global_counter = 64'h0123_4567_89AB_0000;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic [10:0] out_len;
  logic        out_crc_ok;
  logic        out_err;
  logic [63:0] out_tstamp;
  logic [31:0] frame_cnt;
  logic [31:0] err_cnt;

  always #4 gmii_rx_clk = ~gmii_rx_clk;
  always @(negedge gmii_rx_clk) global_counter <= global_counter + 64'd13;

  gmii_rx_framer dut (
    .gmii_rx_clk(gmii_rx_clk), .sys_rst_n(sys_rst_n), .gmii_rxd(gmii_rxd),
    .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er), .global_counter(global_counter),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
    .out_len(out_len), .out_crc_ok(out_crc_ok), .out_err(out_err), .out_tstamp(out_tstamp),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  typedef struct packed {
    logic [7:0]  data;
    logic        sof;
    logic        eof;
    logic [10:0] len;
    logic        crc_ok;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_frame_cnt = 32'd0;
  logic [31:0] exp_err_cnt = 32'd0;
  logic [63:0] exp_ts = 64'd0;
  logic [10:0] last_len = 11'd0;
  logic        last_crc_ok = 1'b0;
  logic        last_err = 1'b0;
  int          byte_seen = 0;
  int          sof_seen = 0;
  logic [7:0]  frm [0:2047];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Standard Ethernet CRC-32 over frm[0..n-1], final complement applied.
  function automatic logic [31:0] crc32(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input int n, input int seed);
    logic [31:0] f;
    for (int i = 0; i < n - 4; i++) frm[i] = 8'((i * 7 + seed) & 255);
    f = crc32(n - 4);
    frm[n-4] = f[7:0];
    frm[n-3] = f[15:8];
    frm[n-2] = f[23:16];
    frm[n-1] = f[31:24];
  endtask

  // Expected delivery: every byte in order, status on the last one only.
  task automatic model_frame(input int n, input bit er);
    bit   fcs_ok;
    bit   bad;
    exp_t e;
    fcs_ok = 1'b0;
    if (n >= 4) fcs_ok = ({frm[n-1], frm[n-2], frm[n-3], frm[n-4]} == crc32(n - 4));
    bad = !fcs_ok || (n < 64) || (n > 1518) || er;
    for (int i = 0; i < n; i++) begin
      e.data   = frm[i];
      e.sof    = (i == 0);
      e.eof    = (i == n - 1);
      e.len    = (i == n - 1) ? ((n > 2047) ? 11'd2047 : 11'(n)) : 11'd0;
      e.crc_ok = (i == n - 1) && fcs_ok;
      e.err    = (i == n - 1) && bad;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic er);
    @(negedge gmii_rx_clk);
    gmii_rxd   = d;
    gmii_rx_dv = v;
    gmii_rx_er = er;
  endtask

  task automatic send(input int npre, input logic [7:0] sfd, input int n,
                      input int er_at, input int rst_at, input int idle);
    bit acc;
    acc = (npre >= 2) && (sfd == 8'hD5);
    for (int p = 0; p < npre; p++) drive(8'h55, 1'b1, 1'b0);
    drive(sfd, 1'b1, 1'b0);
    @(posedge gmii_rx_clk);
    if (acc) begin
      exp_ts = global_counter;
      if (n > 0) model_frame(n, er_at >= 0 && er_at < n);
    end
    for (int i = 0; i < n; i++) begin
      @(negedge gmii_rx_clk);
      gmii_rxd   = frm[i];
      gmii_rx_dv = 1'b1;
      gmii_rx_er = (i == er_at);
      sys_rst_n  = (i != rst_at);
      if (i == rst_at) begin
        exp_q.delete();
        exp_frame_cnt = 32'd0;
        exp_err_cnt   = 32'd0;
        exp_ts        = 64'd0;
      end
    end
    drive(8'h00, 1'b0, 1'b0);
    sys_rst_n = 1'b1;
    repeat (idle) @(negedge gmii_rx_clk);
  endtask

  always begin
    exp_t e;
    @(posedge gmii_rx_clk);
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_sof", 64'(out_sof), 64'(e.sof));
        check("out_eof", 64'(out_eof), 64'(e.eof));
        check("out_len", 64'(out_len), 64'(e.len));
        check("out_crc_ok", 64'(out_crc_ok), 64'(e.crc_ok));
        check("out_err", 64'(out_err), 64'(e.err));
        if (e.eof) begin
          exp_frame_cnt = exp_frame_cnt + 32'd1;
          if (e.err) exp_err_cnt = exp_err_cnt + 32'd1;
          last_len    = out_len;
          last_crc_ok = out_crc_ok;
          last_err    = out_err;
        end
        byte_seen++;
        if (out_sof) sof_seen++;
      end
    end else begin
      check("idle_status_zero", {48'd0, out_data, out_sof, out_eof, out_len, out_crc_ok, out_err}, 64'd0);
    end
    check("frame_cnt", 64'(frame_cnt), 64'(exp_frame_cnt));
    check("err_cnt", 64'(err_cnt), 64'(exp_err_cnt));
    check("out_tstamp", out_tstamp, exp_ts);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n  = 1'b0;
    gmii_rxd   = 8'd0;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    repeat (3) @(negedge gmii_rx_clk);
    sys_rst_n = 1'b1;

    for (int i = 0; i < 9; i++) frm[i] = 8'h31 + 8'(i);
    check("model_crc_123456789", 64'(crc32(9)), 64'h0000_0000_CBF4_3926);
    check("reset_frame_cnt", 64'(frame_cnt), 64'd0);
    check("reset_tstamp", out_tstamp, 64'd0);

    build_frame(64, 3);
    send(7, 8'hD5, 64, -1, -1, 3);
    check("good64_len", 64'(last_len), 64'd64);
    check("good64_crc_ok", 64'(last_crc_ok), 64'd1);
    check("good64_err", 64'(last_err), 64'd0);
    check("good64_frame_cnt", 64'(frame_cnt), 64'd1);
    check("good64_bytes", 64'(byte_seen), 64'd64);
    check("good64_sof", 64'(sof_seen), 64'd1);

    build_frame(64, 3);
    frm[10] = frm[10] ^ 8'h04;
    send(7, 8'hD5, 64, -1, -1, 3);
    check("flip_crc_ok", 64'(last_crc_ok), 64'd0);
    check("flip_err", 64'(last_err), 64'd1);
    check("flip_err_cnt", 64'(err_cnt), 64'd1);

    build_frame(64, 9);
    send(1, 8'hD5, 20, -1, -1, 2);
    send(0, 8'h00, 20, -1, -1, 2);
    check("drop_frame_cnt", 64'(frame_cnt), 64'd2);
    check("drop_bytes", 64'(byte_seen), 64'd128);

    build_frame(40, 5);
    send(7, 8'hD5, 40, -1, -1, 3);
    check("runt_len", 64'(last_len), 64'd40);
    check("runt_crc_ok", 64'(last_crc_ok), 64'd1);
    check("runt_err", 64'(last_err), 64'd1);

    build_frame(1600, 1);
    send(7, 8'hD5, 1600, -1, -1, 3);
    check("big_len", 64'(last_len), 64'd1600);
    check("big_err", 64'(last_err), 64'd1);

    build_frame(64, 11);
    send(3, 8'hD5, 64, 30, -1, 3);
    check("rxer_crc_ok", 64'(last_crc_ok), 64'd1);
    check("rxer_err", 64'(last_err), 64'd1);
    check("rxer_err_cnt", 64'(err_cnt), 64'd4);

    build_frame(64, 21);
    send(2, 8'hD5, 64, -1, -1, 0);
    send(2, 8'hD5, 64, -1, -1, 3);
    check("b2b_frame_cnt", 64'(frame_cnt), 64'd7);
    check("b2b_err_cnt", 64'(err_cnt), 64'd4);

    build_frame(64, 2);
    send(7, 8'hD5, 64, -1, 20, 3);
    check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("midrst_tstamp", out_tstamp, 64'd0);
    send(7, 8'hD5, 64, -1, -1, 3);
    check("postrst_frame_cnt", 64'(frame_cnt), 64'd1);
    check("postrst_err", 64'(last_err), 64'd0);

    send(7, 8'hD5, 0, -1, -1, 3);
    check("empty_frame_cnt", 64'(frame_cnt), 64'd1);

    @(negedge gmii_rx_clk);
    force dut.err_cnt = 32'hFFFF_FFFF;
    exp_err_cnt = 32'hFFFF_FFFF;
    repeat (2) @(negedge gmii_rx_clk);
    release dut.err_cnt;
    build_frame(64, 7);
    frm[30] = frm[30] ^ 8'h80;
    send(7, 8'hD5, 64, -1, -1, 3);
    check("wrap_err_cnt", 64'(err_cnt), 64'd0);
    check("wrap_frame_cnt", 64'(frame_cnt), 64'd2);

    repeat (4) @(negedge gmii_rx_clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
